// File: rtl/mips_muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the MIPS EX stage.
// Multiplies finish after MUL_LATENCY cycles; divides take WIDTH iterations plus a fix-up cycle.
module mips_muldiv_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} stateT;

    stateT            stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic [WIDTH-1:0] hiQ, hiD, loQ, loD;
    logic [WIDTH-1:0] opAQ, opAD, opBQ, opBD;
    logic [WIDTH-1:0] remQ, remD, quoQ, quoD, divsQ, divsD;
    logic             signedQ, signedD;
    logic             doneQ, doneD;

    logic [2*WIDTH-1:0] extA, extB, product;
    logic [WIDTH-1:0]   absA, absB, quoFix, remFix;
    logic [WIDTH:0]     shifted, diff;
    logic               divSigned, negQuo, negRem, divZero, lastMul, lastDiv;

    always_comb begin
        extA    = {{WIDTH{signedQ & opAQ[WIDTH-1]}}, opAQ};
        extB    = {{WIDTH{signedQ & opBQ[WIDTH-1]}}, opBQ};
        // Low 2*WIDTH bits of the sign-extended product equal the signed product.
        product = extA * extB;

        divSigned = (op == OpDiv);
        absA = (divSigned && a[WIDTH-1]) ? (~a + 1'b1) : a;
        absB = (divSigned && b[WIDTH-1]) ? (~b + 1'b1) : b;

        shifted = {remQ, quoQ[WIDTH-1]};
        diff    = shifted - {1'b0, divsQ};

        negQuo  = signedQ & (opAQ[WIDTH-1] ^ opBQ[WIDTH-1]);
        negRem  = signedQ & opAQ[WIDTH-1];
        quoFix  = negQuo ? (~quoQ + 1'b1) : quoQ;
        remFix  = negRem ? (~remQ + 1'b1) : remQ;
        divZero = (opBQ == '0);

        lastMul = (cntQ == CNT_W'(MUL_LATENCY - 1));
        lastDiv = (cntQ == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        hiD     = hiQ;
        loD     = loQ;
        opAD    = opAQ;
        opBD    = opBQ;
        remD    = remQ;
        quoD    = quoQ;
        divsD   = divsQ;
        signedD = signedQ;
        doneD   = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (start && !flush) begin
                    case (op)
                        OpMthi: hiD = a;
                        OpMtlo: loD = a;
                        OpMult, OpMultu: begin
                            opAD    = a;
                            opBD    = b;
                            signedD = (op == OpMult);
                            cntD    = '0;
                            stateD  = StMul;
                        end
                        OpDiv, OpDivu: begin
                            opAD    = a;
                            opBD    = b;
                            signedD = divSigned;
                            remD    = '0;
                            quoD    = absA;
                            divsD   = absB;
                            cntD    = '0;
                            stateD  = StDiv;
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (flush) begin
                    stateD = StIdle;
                end else if (lastMul) begin
                    {hiD, loD} = product;
                    doneD      = 1'b1;
                    stateD     = StIdle;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            StDiv: begin
                if (flush) begin
                    stateD = StIdle;
                end else begin
                    // Restoring step: keep the trial subtraction only if it did not borrow.
                    if (!diff[WIDTH]) begin
                        remD = diff[WIDTH-1:0];
                        quoD = {quoQ[WIDTH-2:0], 1'b1};
                    end else begin
                        remD = shifted[WIDTH-1:0];
                        quoD = {quoQ[WIDTH-2:0], 1'b0};
                    end
                    cntD = cntQ + 1'b1;
                    if (lastDiv) begin
                        stateD = StFix;
                    end
                end
            end
            StFix: begin
                if (flush) begin
                    stateD = StIdle;
                end else begin
                    if (divZero) begin
                        loD = '1;
                        hiD = opAQ;
                    end else begin
                        loD = quoFix;
                        hiD = remFix;
                    end
                    doneD  = 1'b1;
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ  <= StIdle;
            cntQ    <= '0;
            hiQ     <= '0;
            loQ     <= '0;
            opAQ    <= '0;
            opBQ    <= '0;
            remQ    <= '0;
            quoQ    <= '0;
            divsQ   <= '0;
            signedQ <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            hiQ     <= hiD;
            loQ     <= loD;
            opAQ    <= opAD;
            opBQ    <= opBD;
            remQ    <= remD;
            quoQ    <= quoD;
            divsQ   <= divsD;
            signedQ <= signedD;
            doneQ   <= doneD;
        end
    end

    assign busy = (stateQ != StIdle);
    assign done = doneQ;
    assign hi   = hiQ;
    assign lo   = loQ;

endmodule
